gaussian_stats_accum: RTL

- Downstream consumer of the 128-bit Gaussian noise stream (sim_data) from the 12-bit LFSR noise generator.
- Over a programmable window it accumulates sum, sum of squares, min and max of all 8 samples per clock.
- Firmware and benches use the results to check noise mean, RMS and rail behaviour before the stream is injected into the trigger path.

---
 rtl/gaussian_stats_accum.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/gaussian_stats_accum.sv
// Windowed sum / sum-of-squares / min / max over the packed Gaussian noise stream.
// Define GAUSS_STATS_SATCNT_EN to build the rail-hit counter behind sat_cnt_o.

module gaussian_stats_lane #(
  parameter int SAMP_BITS = 12
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic [SAMP_BITS-1:0]   samp,
  output logic [SAMP_BITS-1:0]   samp_q,
  output logic [2*SAMP_BITS-2:0] sq_q
);
  // A square never exceeds 2^(2*SAMP_BITS-2), so a product modulo 2^(2*SAMP_BITS-1) is exact.
  logic [2*SAMP_BITS-2:0] sx, prod;
  assign sx   = {{(SAMP_BITS-1){samp[SAMP_BITS-1]}}, samp};
  assign prod = sx * sx;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      samp_q <= '0;
      sq_q   <= '0;
    end else begin
      samp_q <= samp;
      sq_q   <= prod;
    end
  end
endmodule

module gaussian_stats_accum #(
  parameter int NSAMP     = 8,
  parameter int SAMP_BITS = 12,
  parameter int WIN_LOG2  = 16
) (
  input  logic                                 clk,
  input  logic                                 rstn_i,
  input  logic [16*NSAMP-1:0]                  sim_data,
  input  logic                                 data_valid_i,
  input  logic                                 start_i,
  input  logic                                 ack_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic signed [SAMP_BITS+3+WIN_LOG2-1:0] sum_o,
  output logic [2*SAMP_BITS+3+WIN_LOG2-1:0]    sumsq_o,
  output logic signed [SAMP_BITS-1:0]          min_o,
  output logic signed [SAMP_BITS-1:0]          max_o,
  output logic [4+WIN_LOG2-1:0]                sat_cnt_o
);
  localparam int LG     = $clog2(NSAMP);
  localparam int STAGES = 3;
  localparam int LSB    = 16 - SAMP_BITS;
  localparam int SUM_W  = SAMP_BITS + 3 + WIN_LOG2;
  localparam int SQ_W   = 2*SAMP_BITS + 3 + WIN_LOG2;
  localparam int BS_W   = SAMP_BITS + LG;
  localparam int BQ_W   = 2*SAMP_BITS - 1 + LG;
  localparam logic signed [SAMP_BITS-1:0] S_MAX = {1'b0, {(SAMP_BITS-1){1'b1}}};
  localparam logic signed [SAMP_BITS-1:0] S_MIN = {1'b1, {(SAMP_BITS-1){1'b0}}};
  localparam logic [WIN_LOG2:0] LAST = {1'b0, {WIN_LOG2{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state;
  logic [WIN_LOG2:0]   beat_cnt;
  logic [1:0]          flush_cnt;
  logic                capture, clr;
  logic [STAGES:1]     vld_pipe;

  logic [NSAMP-1:0][SAMP_BITS-1:0]   s1_samp, s2_samp;
  logic [NSAMP-1:0][2*SAMP_BITS-2:0] s2_sq;
  logic signed [BS_W-1:0]            bsum, s3_sum;
  logic [BQ_W-1:0]                   bsq, s3_sq;
  logic signed [SAMP_BITS-1:0]       bmin, bmax, s3_min, s3_max;
  logic                              unused_lsb;

  assign capture = (state == RUN) && data_valid_i;
  assign clr     = (state == IDLE) && start_i;

  // Lane bits below the MSB-aligned sample carry no information.
  always_comb begin
    unused_lsb = 1'b0;
    for (int k = 0; k < NSAMP; k++) unused_lsb = unused_lsb ^ (^sim_data[16*k +: LSB]);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state    <= RUN;
          beat_cnt <= '0;
          busy_o   <= 1'b1;
        end
        RUN: if (data_valid_i) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == LAST) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        // Drain until the final beat lands in the accumulators.
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == 2'd2) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE: if (ack_i) begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NSAMP; k++) begin : g_lane
    gaussian_stats_lane #(.SAMP_BITS(SAMP_BITS)) u_lane (
      .clk    (clk),
      .rstn_i (rstn_i),
      .samp   (s1_samp[k]),
      .samp_q (s2_samp[k]),
      .sq_q   (s2_sq[k])
    );
  end

  always_comb begin
    bsum = '0;
    bsq  = '0;
    bmin = S_MAX;
    bmax = S_MIN;
    for (int k = 0; k < NSAMP; k++) begin
      bsum = bsum + {{LG{s2_samp[k][SAMP_BITS-1]}}, s2_samp[k]};
      bsq  = bsq + {{LG{1'b0}}, s2_sq[k]};
      if ($signed(s2_samp[k]) < bmin) bmin = s2_samp[k];
      if ($signed(s2_samp[k]) > bmax) bmax = s2_samp[k];
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_pipe <= '0;
      s1_samp  <= '0;
      s3_sum   <= '0;
      s3_sq    <= '0;
      s3_min   <= S_MAX;
      s3_max   <= S_MIN;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], capture};
      for (int k = 0; k < NSAMP; k++) s1_samp[k] <= sim_data[16*k+LSB +: SAMP_BITS];
      s3_sum <= bsum;
      s3_sq  <= bsq;
      s3_min <= bmin;
      s3_max <= bmax;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sum_o   <= '0;
      sumsq_o <= '0;
      min_o   <= S_MAX;
      max_o   <= S_MIN;
    end else if (clr) begin
      sum_o   <= '0;
      sumsq_o <= '0;
      min_o   <= S_MAX;
      max_o   <= S_MIN;
    end else if (vld_pipe[STAGES]) begin
      sum_o   <= sum_o + {{(SUM_W-BS_W){s3_sum[BS_W-1]}}, s3_sum};
      sumsq_o <= sumsq_o + {{(SQ_W-BQ_W){1'b0}}, s3_sq};
      if (s3_min < min_o) min_o <= s3_min;
      if (s3_max > max_o) max_o <= s3_max;
    end
  end

`ifdef GAUSS_STATS_SATCNT_EN
  // One bit wider than the sums' growth so a window where every sample is on a rail still fits.
  logic [LG:0] brail, s3_rail;
  always_comb begin
    brail = '0;
    for (int k = 0; k < NSAMP; k++)
      brail = brail + {{LG{1'b0}}, (s2_samp[k] == S_MAX || s2_samp[k] == S_MIN)};
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      s3_rail   <= '0;
      sat_cnt_o <= '0;
    end else begin
      s3_rail <= brail;
      if (clr)                   sat_cnt_o <= '0;
      else if (vld_pipe[STAGES]) sat_cnt_o <= sat_cnt_o + {{(4+WIN_LOG2-LG-1){1'b0}}, s3_rail};
    end
  end
`else
  assign sat_cnt_o = '0;
`endif

endmodule
